// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control definitions: opcode/funct maps, ALU encodings and the
// E-stage control word carried by the pipelined control unit.
package mips_ctrl_pkg;

    localparam logic [5:0] op_rtype = 6'b000000;
    localparam logic [5:0] op_lw    = 6'b100011;
    localparam logic [5:0] op_sw    = 6'b101011;
    localparam logic [5:0] op_addi  = 6'b001000;
    localparam logic [5:0] op_beq   = 6'b000100;
    localparam logic [5:0] op_j     = 6'b000010;
    localparam logic [5:0] op_push  = 6'b100000;
    localparam logic [5:0] op_pop   = 6'b101000;

    localparam logic [5:0] fn_and = 6'b100100;
    localparam logic [5:0] fn_or  = 6'b100101;
    localparam logic [5:0] fn_add = 6'b100000;
    localparam logic [5:0] fn_sub = 6'b100010;
    localparam logic [5:0] fn_slt = 6'b101010;
    localparam logic [5:0] fn_mul = 6'b011100;

    localparam logic [2:0] alu_and = 3'b000;
    localparam logic [2:0] alu_or  = 3'b001;
    localparam logic [2:0] alu_add = 3'b010;
    localparam logic [2:0] alu_sub = 3'b100;
    localparam logic [2:0] alu_slt = 3'b110;
    localparam logic [2:0] alu_mul = 3'b101;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_write;
        logic       alu_src;
        logic       reg_dst;
        logic       branch;
        logic       jump;
        logic       push;
        logic       pop;
        logic       mem_src;
        logic [2:0] alu_control;
    } ctrl_word_t;

    localparam ctrl_word_t BUBBLE = '{
        reg_write: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0, alu_src: 1'b0,
        reg_dst: 1'b0, branch: 1'b0, jump: 1'b0, push: 1'b0, pop: 1'b0,
        mem_src: 1'b0, alu_control: alu_add
    };

    function automatic logic [2:0] alu_from_funct(input logic [5:0] funct);
        case (funct)
            fn_and:  return alu_and;
            fn_or:   return alu_or;
            fn_add:  return alu_add;
            fn_sub:  return alu_sub;
            fn_slt:  return alu_slt;
            fn_mul:  return alu_mul;
            default: return alu_add;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Combinational D-stage decoder: instruction to control word, plus flags for
// recognised instructions and multi-cycle MUL.
module ctrl_decoder
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic [INSTR_W-1:0] Instruction,
    output ctrl_word_t         ctrl,
    output logic               known,
    output logic               is_mul
);

    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = Instruction[INSTR_W-1 -: 6];
    assign funct  = Instruction[5:0];

    always_comb begin
        ctrl   = BUBBLE;
        known  = 1'b1;
        is_mul = 1'b0;
        case (opcode)
            op_rtype: begin
                ctrl.reg_write   = 1'b1;
                ctrl.reg_dst     = 1'b1;
                ctrl.alu_control = alu_from_funct(funct);
                is_mul           = (funct == fn_mul);
            end
            op_lw: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.mem_src    = 1'b1;
            end
            op_sw: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            op_addi: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src   = 1'b1;
            end
            op_beq: begin
                ctrl.branch      = 1'b1;
                ctrl.alu_control = alu_sub;
            end
            op_j:    ctrl.jump = 1'b1;
            op_push: begin
                ctrl.reg_write  = 1'b1;
                ctrl.alu_src    = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.push       = 1'b1;
            end
            op_pop: begin
                ctrl.alu_src = 1'b1;
                ctrl.pop     = 1'b1;
            end
            default: known = 1'b0;
        endcase
        // An all-zero word is the pipeline's NOP and must never reach E.
        if (Instruction == '0) begin
            known  = 1'b0;
            is_mul = 1'b0;
        end
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// ID/EX control register with multi-cycle MUL sequencing, hazard flush and
// stack-occupancy tracking around the combinational decoder.
module pipelined_control_unit
    import mips_ctrl_pkg::*;
#(
    parameter int INSTR_W     = 32,
    parameter int MUL_LATENCY = 4,
    parameter int STACK_DEPTH = 16
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic [INSTR_W-1:0]               Instruction,
    input  logic                             Valid_D,
    input  logic                             Flush_E,
    output logic                             RegWrite_E,
    output logic                             MemtoReg_E,
    output logic                             MemWrite_E,
    output logic                             ALUSrc_E,
    output logic                             RegDst_E,
    output logic                             Branch_E,
    output logic                             Jump_E,
    output logic                             Push_E,
    output logic                             Pop_E,
    output logic                             MemSrc_E,
    output logic [2:0]                       ALUControl_E,
    output logic                             Valid_E,
    output logic                             Busy,
    output logic [$clog2(STACK_DEPTH+1)-1:0] StackCount,
    output logic                             Overflow,
    output logic                             Underflow
);

    localparam int SC_W = $clog2(STACK_DEPTH + 1);
    localparam int MC_W = $clog2(MUL_LATENCY + 1);

    typedef enum logic {RUN, MUL_BUSY} state_t;

    state_t            state, state_nxt;
    logic [MC_W-1:0]   mul_cnt, mul_cnt_nxt;
    ctrl_word_t        e_ctrl_p0, e_ctrl_nxt;
    logic              vld_p0, vld_nxt;
    logic [SC_W-1:0]   cnt, cnt_nxt;
    logic              ovf, ovf_nxt, unf, unf_nxt;
    ctrl_word_t        dec;
    logic              dec_ok, dec_mul;

    ctrl_decoder #(.INSTR_W(INSTR_W)) u_dec (
        .Instruction (Instruction),
        .ctrl        (dec),
        .known       (dec_ok),
        .is_mul      (dec_mul)
    );

    always_comb begin
        state_nxt   = state;
        mul_cnt_nxt = mul_cnt;
        e_ctrl_nxt  = e_ctrl_p0;
        vld_nxt     = vld_p0;
        cnt_nxt     = cnt;
        ovf_nxt     = ovf;
        unf_nxt     = unf;
        case (state)
            RUN: begin
                e_ctrl_nxt  = BUBBLE;
                vld_nxt     = 1'b0;
                mul_cnt_nxt = '0;
                if (!Flush_E && Valid_D && dec_ok) begin
                    if (dec.push && cnt == SC_W'(STACK_DEPTH)) begin
                        ovf_nxt = 1'b1;
                    end else if (dec.pop && cnt == '0) begin
                        unf_nxt = 1'b1;
                    end else begin
                        e_ctrl_nxt = dec;
                        vld_nxt    = 1'b1;
                        if (dec.push) cnt_nxt = cnt + SC_W'(1);
                        if (dec.pop)  cnt_nxt = cnt - SC_W'(1);
                        // The write-back is withheld until the last MUL cycle.
                        if (dec_mul && MUL_LATENCY > 1) begin
                            e_ctrl_nxt.reg_write = 1'b0;
                            state_nxt            = MUL_BUSY;
                            mul_cnt_nxt          = MC_W'(MUL_LATENCY - 1);
                        end
                    end
                end
            end
            MUL_BUSY: begin
                if (Flush_E) begin
                    e_ctrl_nxt  = BUBBLE;
                    vld_nxt     = 1'b0;
                    state_nxt   = RUN;
                    mul_cnt_nxt = '0;
                end else if (mul_cnt == MC_W'(1)) begin
                    e_ctrl_nxt.reg_write = 1'b1;
                    state_nxt            = RUN;
                    mul_cnt_nxt          = '0;
                end else begin
                    mul_cnt_nxt = mul_cnt - MC_W'(1);
                end
            end
            default: state_nxt = RUN;
        endcase
    end

    // ID/EX register boundary
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= RUN;
            mul_cnt   <= '0;
            e_ctrl_p0 <= BUBBLE;
            vld_p0    <= 1'b0;
            cnt       <= '0;
            ovf       <= 1'b0;
            unf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            mul_cnt   <= mul_cnt_nxt;
            e_ctrl_p0 <= e_ctrl_nxt;
            vld_p0    <= vld_nxt;
            cnt       <= cnt_nxt;
            ovf       <= ovf_nxt;
            unf       <= unf_nxt;
        end
    end

    assign RegWrite_E   = e_ctrl_p0.reg_write;
    assign MemtoReg_E   = e_ctrl_p0.mem_to_reg;
    assign MemWrite_E   = e_ctrl_p0.mem_write;
    assign ALUSrc_E     = e_ctrl_p0.alu_src;
    assign RegDst_E     = e_ctrl_p0.reg_dst;
    assign Branch_E     = e_ctrl_p0.branch;
    assign Jump_E       = e_ctrl_p0.jump;
    assign Push_E       = e_ctrl_p0.push;
    assign Pop_E        = e_ctrl_p0.pop;
    assign MemSrc_E     = e_ctrl_p0.mem_src;
    assign ALUControl_E = e_ctrl_p0.alu_control;
    assign Valid_E      = vld_p0;
    assign Busy         = (state == MUL_BUSY);
    assign StackCount   = cnt;
    assign Overflow     = ovf;
    assign Underflow    = unf;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Bench for pipelined_control_unit: directed scenarios followed by random
// traffic, compared each cycle against a queue-based behavioural model.
module tb_pipelined_control_unit;

    localparam int LAT   = 4;
    localparam int DEPTH = 2;
    localparam int SC_W  = $clog2(DEPTH + 1);
    localparam logic [12:0] BUB = 13'b0_0000_0000_0010;
    localparam logic [12:0] RW  = 13'h1000;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic [31:0]     Instruction = '0;
    logic            Valid_D = 1'b0;
    logic            Flush_E = 1'b0;
    logic            RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E;
    logic            Branch_E, Jump_E, Push_E, Pop_E, MemSrc_E;
    logic [2:0]      ALUControl_E;
    logic            Valid_E, Busy, Overflow, Underflow;
    logic [SC_W-1:0] StackCount;

    int checks = 0;
    int errors = 0;

    logic [12:0] m_word;
    bit          m_vld, m_ovf, m_unf;
    int          m_cnt;
    logic [12:0] m_q[$];

    pipelined_control_unit #(.INSTR_W(32), .MUL_LATENCY(LAT), .STACK_DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST(RST), .Instruction(Instruction), .Valid_D(Valid_D),
        .Flush_E(Flush_E), .RegWrite_E(RegWrite_E), .MemtoReg_E(MemtoReg_E),
        .MemWrite_E(MemWrite_E), .ALUSrc_E(ALUSrc_E), .RegDst_E(RegDst_E),
        .Branch_E(Branch_E), .Jump_E(Jump_E), .Push_E(Push_E), .Pop_E(Pop_E),
        .MemSrc_E(MemSrc_E), .ALUControl_E(ALUControl_E), .Valid_E(Valid_E),
        .Busy(Busy), .StackCount(StackCount), .Overflow(Overflow), .Underflow(Underflow)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Word layout {rw,mtr,mw,as,rd,br,j,push,pop,ms,alu[2:0]}
    task automatic ref_decode(input logic [31:0] ins, output logic [12:0] w,
                              output bit ok, output bit mul);
        logic [5:0] f;
        logic [2:0] alu;
        f = ins[5:0];
        ok = 1'b1;
        mul = 1'b0;
        w = BUB;
        case (ins[31:26])
            6'h00: begin
                case (f)
                    6'h24: alu = 3'b000;
                    6'h25: alu = 3'b001;
                    6'h22: alu = 3'b100;
                    6'h2a: alu = 3'b110;
                    6'h1c: alu = 3'b101;
                    default: alu = 3'b010;
                endcase
                w = {10'b1000_1000_00, alu};
                mul = (f == 6'h1c);
            end
            6'h23: w = 13'b1101_0000_01_010;
            6'h2b: w = 13'b0011_0000_00_010;
            6'h08: w = 13'b1001_0000_00_010;
            6'h04: w = 13'b0000_0100_00_100;
            6'h02: w = 13'b0000_0010_00_010;
            6'h20: w = 13'b1101_0001_00_010;
            6'h28: w = 13'b0001_0000_10_010;
            default: ok = 1'b0;
        endcase
        if (ins == 32'h0) ok = 1'b0;
    endtask

    task automatic model_edge(input bit rst, input logic [31:0] ins, input bit vd, input bit fl);
        logic [12:0] w;
        bit ok, mul;
        if (rst) begin
            m_word = BUB; m_vld = 0; m_cnt = 0; m_ovf = 0; m_unf = 0;
            m_q.delete();
        end else if (m_q.size() > 0) begin
            if (fl) begin
                m_q.delete();
                m_word = BUB;
                m_vld = 0;
            end else begin
                m_word = m_q.pop_front();
            end
        end else begin
            m_word = BUB;
            m_vld = 0;
            if (!fl && vd) begin
                ref_decode(ins, w, ok, mul);
                if (ok) begin
                    if (w[5] && m_cnt == DEPTH) m_ovf = 1;
                    else if (w[4] && m_cnt == 0) m_unf = 1;
                    else begin
                        m_vld = 1;
                        if (w[5]) m_cnt++;
                        if (w[4]) m_cnt--;
                        if (mul && LAT > 1) begin
                            m_word = w & ~RW;
                            for (int i = 0; i < LAT - 2; i++) m_q.push_back(w & ~RW);
                            m_q.push_back(w);
                        end else begin
                            m_word = w;
                        end
                    end
                end
            end
        end
    endtask

    task automatic cycle(input bit rst, input logic [31:0] ins, input bit vd, input bit fl);
        @(negedge CLK);
        RST = rst; Instruction = ins; Valid_D = vd; Flush_E = fl;
        @(posedge CLK);
        model_edge(rst, ins, vd, fl);
        #1;
        chk("ctrl", {RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E, Branch_E,
                     Jump_E, Push_E, Pop_E, MemSrc_E, ALUControl_E}, m_word);
        chk("valid", Valid_E, m_vld);
        chk("busy", Busy, m_q.size() > 0);
        chk("stack", StackCount, m_cnt);
        chk("ovf", Overflow, m_ovf);
        chk("unf", Underflow, m_unf);
    endtask

    localparam logic [31:0] ADD = 32'h012A4020, SUB = 32'h012A4022, MUL = 32'h012A401C;
    localparam logic [31:0] PUSH = 32'h81280000, POP = 32'hA1280000;

    logic [31:0] tmpl [16] = '{32'h012A4020, 32'h012A4022, 32'h012A4024, 32'h012A4025,
                               32'h012A402A, 32'h012A401C, 32'h012A4031, 32'h8D280004,
                               32'hAD280004, 32'h21280004, 32'h11280004, 32'h08000010,
                               32'h81280000, 32'hA1280000, 32'h00000000, 32'hFC000000};

    initial begin
        logic [31:0] ins;
        int k;
        cycle(1, ADD, 1, 0);
        cycle(1, ADD, 1, 0);
        chk("rst_alu", ALUControl_E, 3'b010);
        chk("rst_busy", Busy, 1'b0);

        cycle(0, ADD, 1, 0);
        chk("add_alu", ALUControl_E, 3'b010);
        cycle(0, SUB, 1, 0);
        chk("sub_alu", ALUControl_E, 3'b100);
        chk("sub_regdst", RegDst_E, 1'b1);

        cycle(0, MUL, 1, 0);
        chk("mul1_rw", RegWrite_E, 1'b0);
        chk("mul1_busy", Busy, 1'b1);
        cycle(0, MUL, 1, 0);
        cycle(0, MUL, 1, 0);
        chk("mul3_busy", Busy, 1'b1);
        cycle(0, MUL, 1, 0);
        chk("mul4_rw", RegWrite_E, 1'b1);
        chk("mul4_alu", ALUControl_E, 3'b101);
        chk("mul4_busy", Busy, 1'b0);

        cycle(0, MUL, 1, 0);
        cycle(0, MUL, 1, 0);
        cycle(0, MUL, 1, 1);
        chk("flush_busy", Busy, 1'b0);
        chk("flush_rw", RegWrite_E, 1'b0);
        chk("flush_valid", Valid_E, 1'b0);
        cycle(0, 32'h0, 0, 0);

        cycle(1, 0, 0, 0);
        cycle(0, PUSH, 1, 0);
        chk("push1_cnt", StackCount, 1);
        cycle(0, PUSH, 1, 0);
        chk("push2_cnt", StackCount, 2);
        cycle(0, PUSH, 1, 0);
        chk("push3_cnt", StackCount, 2);
        chk("push3_ovf", Overflow, 1'b1);
        chk("push3_bubble", Push_E, 1'b0);
        cycle(0, ADD, 1, 0);
        chk("ovf_sticky", Overflow, 1'b1);

        cycle(1, 0, 0, 0);
        cycle(0, POP, 1, 0);
        chk("pop_unf", Underflow, 1'b1);
        chk("pop_cnt", StackCount, 0);
        chk("pop_bubble", Pop_E, 1'b0);
        cycle(0, PUSH, 1, 1);
        chk("flushpush_cnt", StackCount, 0);

        for (int n = 0; n < 600; n++) begin
            k = (($urandom % 4) == 0) ? 12 + int'($urandom % 2) : int'($urandom % 16);
            ins = tmpl[k];
            if (ins != 32'h0 && k < 14) ins = ins | ($urandom & 32'h03FFFFC0);
            cycle(($urandom % 97) == 0, ins, ($urandom % 8) != 0, ($urandom % 12) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_control_unit.md
# pipelined_control_unit

Second-generation MIPS control unit: decodes the D-stage instruction with the existing opcode/funct map and registers the decoded control word into the ID/EX (E-stage) control register. It adds sequential behaviour the purely combinational decoder lacks:
- a multi-cycle MUL sequencer that holds the E-stage control word and stalls upstream;
- a hazard-unit flush input;
- a stack-occupancy tracker that suppresses push overflow and pop underflow.

It sits between the IF/ID register and the E stage of the datapath.

## Interface
Parameters:
- INSTR_W, 32, instruction width; opcode = [INSTR_W-1 -: 6], funct = [5:0].
- MUL_LATENCY, 4, E-stage cycles a MUL occupies; legal range ≥1.
- STACK_DEPTH, 16, number of stack entries; legal range ≥1.

Ports:
- CLK  in  1  clock. Single clock domain.
- RST  in  1  reset. Synchronous, active-high.
- Instruction  in  INSTR_W  D-stage instruction.
- Valid_D  in  1  Instruction is valid this cycle.
- Flush_E  in  1  From the hazard unit: load a bubble into E.
- RegWrite_E, MemtoReg_E, MemWrite_E, ALUSrc_E, RegDst_E, Branch_E, Jump_E, Push_E, Pop_E, MemSrc_E  out  1 each  Registered E-stage controls.
- ALUControl_E  out  3  Registered ALU control.
- Valid_E  out  1  E-stage holds a real instruction.
- Busy  out  1  Stall request for IF/ID. While Busy is high, upstream holds Instruction.
- StackCount  out  $clog2(STACK_DEPTH+1)  Current stack occupancy.
- Overflow, Underflow  out  1 each  Sticky stack error flags.

## Operation
Decode table:
- rType: RegWrite, RegDst; ALUControl from funct: AND=000, OR=001, ADD=010, SUB=100, SLT=110, MUL=101, other=010.
- lw: RegWrite, ALUSrc, MemtoReg, MemSrc; ALUControl=010.
- sw: MemWrite, ALUSrc; ALUControl=010.
- addi: RegWrite, ALUSrc; ALUControl=010.
- beq: Branch; ALUControl=100.
- j: Jump.
- push (100000): RegWrite, ALUSrc, MemtoReg, Push.
- pop (101000): ALUSrc, Pop.

Bubble:
- All control outputs 0, ALUControl=010, Valid_E=0.
- Produced by: Instruction==0, an unknown opcode, Valid_D=0, Flush_E, or a suppressed push/pop.

State machine, states RUN and MUL_BUSY. A down-counter mul_cnt holds the remaining busy cycles.
- In RUN, at each edge, E loads the decode result or a bubble.
- A decoded MUL with MUL_LATENCY>1 is loaded with RegWrite_E=0; the next state is MUL_BUSY and mul_cnt=MUL_LATENCY-1.
- MUL_BUSY:
  - E register holds; input is ignored; Busy=1.
  - mul_cnt decrements each cycle.
  - At an edge where mul_cnt==1, the next state is RUN and RegWrite_E becomes 1 for that final cycle.
- MUL_LATENCY==1: the MUL behaves like any R-type; the FSM never enters MUL_BUSY.
- Flush_E in MUL_BUSY aborts the MUL: the next state is RUN and E loads a bubble, so the MUL never asserts RegWrite_E.

Stack tracking (evaluated only when an instruction is accepted into E in RUN):
- Push with StackCount==STACK_DEPTH: load a bubble and set Overflow. Otherwise increment StackCount.
- Pop with StackCount==0: load a bubble and set Underflow. Otherwise decrement StackCount.
- Flush_E has priority over acceptance: a flushed push/pop changes neither StackCount nor the flags.
- Overflow and Underflow clear only on RST.

## Timing
- Reset: on a clock edge with RST=1, state=RUN, mul_cnt=0, StackCount=0, Overflow=Underflow=0, E register = bubble, Busy=0. RST overrides all other inputs, including mid-MUL.
- Decode-to-E latency: 1 cycle.
- Busy is a combinational function of state only: Busy = (state==MUL_BUSY). It has no combinational path from Instruction.
- MUL sampled at edge t:
  - E holds the MUL control word for cycles t+1 … t+MUL_LATENCY.
  - Busy=1 for cycles t+1 … t+MUL_LATENCY-1.
  - RegWrite_E=1 only in cycle t+MUL_LATENCY.
  - The next instruction is sampled at the end of cycle t+MUL_LATENCY.
- A back-to-back MUL in RUN immediately re-enters MUL_BUSY.

## Structure
- Shared package mips_ctrl_pkg holds:
  - opcode localparams (rType, lw, sw, addi, beq, j, push, pop);
  - funct codes;
  - ALUControl encodings;
  - ctrl_word_t struct;
  - the BUBBLE constant.
- Sub-module ctrl_decoder: purely combinational, Instruction → ctrl_word_t plus an is_mul flag.
- The top level contains the FSM, the E-stage register, the stack counter and the flags.

## Test plan
- Reset: assert RST for 2 cycles with Instruction=0x012A4020 → all controls 0, ALUControl_E=010, Busy=0, StackCount=0.
- ADD then SUB: 0x012A4020 then 0x012A4022, Valid_D=1 → ALUControl_E=010 then 100 on successive cycles; RegWrite_E=1, RegDst_E=1.
- MUL with MUL_LATENCY=4: 0x012A401C → ALUControl_E=101 for 4 cycles, Busy=1 for the first 3, RegWrite_E=1 only in the 4th.
- Flush_E asserted in the 2nd busy cycle of the MUL → next cycle: bubble, Busy=0, RegWrite_E never asserted.
- STACK_DEPTH=2: push 0x81280000 three times → StackCount 1, 2, 2; the 3rd push yields a bubble and Overflow=1 (sticky).
- Pop 0xA1280000 from reset → bubble, Underflow=1, StackCount=0. A push accompanied by Flush_E → StackCount unchanged.
